sigdelt_demod: RTL and testbench

SIGDELT_DEMOD -- requirements
Module: sigdelt_demod

---
 rtl/sigdelt_pkg.sv | 19 +
 rtl/cic_comb_stage.sv | 23 ++
 rtl/sigdelt_demod.sv | 108 ++++++++++
 tb/tb_sigdelt_demod.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sigdelt_pkg.sv
// Shared constants and types for the sigma-delta CIC demodulator.
// SIGDELT_DEMOD_SINC3_EN selects a sinc3 filter; otherwise sinc2.
package sigdelt_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int DEC_LOG2_DEF = 8;

`ifdef SIGDELT_DEMOD_SINC3_EN
  localparam int CIC_N = 3;
`else
  localparam int CIC_N = 2;
`endif

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } demod_st_e;

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator) stage: y = x - x_prev, where x_prev is
// the input captured on the previous enabled decimation event.
module cic_comb_stage #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     dly_q <= '0;
    else if (en_i) dly_q <= x_i;
  end

  // Modulo subtraction undoes any wrap in the upstream integrators.
  assign y_o = x_i - dly_q;

endmodule

// File: rtl/sigdelt_demod.sv
// Sigma-delta bitstream demodulator: N-stage CIC decimator by 2^DEC_LOG2.
// Filter order set by SIGDELT_DEMOD_SINC3_EN (sinc3) or default sinc2.
module sigdelt_demod
  import sigdelt_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEC_LOG2 = DEC_LOG2_DEF
) (
  input  logic              demod_clk,
  input  logic              demod_rst,
  input  logic              demod_din,
  input  logic              din_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_ovr
);

  localparam int ACC_W  = CIC_N * DEC_LOG2 + 1;
  localparam int SHIFT  = (CIC_N * DEC_LOG2 >= DATA_W) ? CIC_N * DEC_LOG2 - DATA_W : 0;
  localparam int FILL_W = $clog2(CIC_N + 1);

  if (CIC_N * DEC_LOG2 < DATA_W) begin : g_width_chk
    $error("sigdelt_demod: CIC gain narrower than DATA_W");
  end

  logic [CIC_N-1:0][ACC_W-1:0] integ_q, integ_d, integ_sum;
  logic [DEC_LOG2-1:0]         cnt_q, cnt_d;
  demod_st_e                   state_q, state_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic [DATA_W-1:0]           dout_q, dout_d;
  logic                        vld_q, vld_d;
  logic                        ovr_q, ovr_d;
  logic [CIC_N:0][ACC_W-1:0]   comb_c;
  logic                        dec_ev;
  logic [DATA_W-1:0]           samp;

  // Integrators see the current bit combinationally so the comb chain
  // samples the sum that includes the R-th bit of the period.
  always_comb begin
    integ_sum[0] = integ_q[0] + ACC_W'(demod_din);
    for (int k = 1; k < CIC_N; k++) integ_sum[k] = integ_q[k] + integ_sum[k-1];
    integ_d = din_en ? integ_sum : integ_q;
  end

  assign dec_ev    = din_en && (cnt_q == '1);
  assign comb_c[0] = integ_sum[CIC_N-1];

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk_i (demod_clk),
      .rst_i (demod_rst),
      .en_i  (dec_ev),
      .x_i   (comb_c[k]),
      .y_o   (comb_c[k+1])
    );
  end

  // Full-scale result is exactly 2^(ACC_W-1): the only value with the MSB set.
  assign samp = comb_c[CIC_N][ACC_W-1] ? '1 : comb_c[CIC_N][SHIFT +: DATA_W];

  always_comb begin
    cnt_d   = din_en ? cnt_q + DEC_LOG2'(1) : cnt_q;
    state_d = state_q;
    fill_d  = fill_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    if (dec_ev && state_q == ST_FILL) begin
      fill_d = fill_q + FILL_W'(1);
      if (fill_q == FILL_W'(CIC_N - 1)) state_d = ST_RUN;
    end
    if (vld_q && dout_ready) vld_d = 1'b0;
    if (dec_ev && state_q == ST_RUN) begin
      if (vld_q && !dout_ready) begin
        ovr_d = 1'b1;
      end else begin
        dout_d = samp;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge demod_clk) begin
    if (demod_rst) begin
      integ_q <= '0;
      cnt_q   <= '0;
      state_q <= ST_FILL;
      fill_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign dout_ovr   = ovr_q;

endmodule

// File: tb/tb_sigdelt_demod.sv
// Randomized bench for sigdelt_demod; reference model convolves the
// qualified bit history with the sinc^N impulse response.
module tb_sigdelt_demod;

  localparam int DATA_W   = 16;
  localparam int DEC_LOG2 = 8;
  localparam int R        = 1 << DEC_LOG2;
`ifdef SIGDELT_DEMOD_SINC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int SHIFT = N * DEC_LOG2 - DATA_W;

  logic              demod_clk = 1'b0;
  logic              demod_rst = 1'b1;
  logic              demod_din = 1'b0;
  logic              din_en    = 1'b0;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ovr;

  sigdelt_demod #(.DATA_W(DATA_W), .DEC_LOG2(DEC_LOG2)) dut (
    .demod_clk  (demod_clk),
    .demod_rst  (demod_rst),
    .demod_din  (demod_din),
    .din_en     (din_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_ovr   (dout_ovr)
  );

  always #5 demod_clk = ~demod_clk;

  int                n_chk = 0;
  int                n_err = 0;
  int                n_vld;
  logic [DATA_W-1:0] last_dout;

  // reference model state
  int                qcnt;
  bit                hist [1024];
  longint            h [];
  logic              exp_vld, exp_ovr;
  logic [DATA_W-1:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void build_h();
    longint tmp [];
    h = new[R];
    foreach (h[i]) h[i] = 1;
    for (int n = 2; n <= N; n++) begin
      tmp = new[h.size() + R - 1];
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      h = tmp;
    end
  endfunction

  function automatic logic [DATA_W-1:0] cic_ref();
    longint y = 0;
    for (int k = 0; k < h.size(); k++) begin
      int t = qcnt - 1 - k;
      if (t >= 0 && hist[t % 1024]) y += h[k];
    end
    if (y == (longint'(1) << (N * DEC_LOG2))) return '1;
    return DATA_W'(y >> SHIFT);
  endfunction

  // One clock: drive, advance the model on the same inputs, then check.
  task automatic step(input logic r, input logic d, input logic e, input logic y);
    logic load;
    demod_rst = r; demod_din = d; din_en = e; dout_ready = y;
    @(posedge demod_clk);
    load = 1'b0;
    if (r) begin
      qcnt = 0; exp_vld = 1'b0; exp_ovr = 1'b0; exp_dout = '0;
    end else begin
      if (e) begin
        hist[qcnt % 1024] = d;
        qcnt++;
        load = (qcnt % R == 0) && (qcnt / R - 1 >= N);
      end
      if (load) begin
        if (exp_vld && !y) exp_ovr = 1'b1;
        else begin exp_dout = cic_ref(); exp_vld = 1'b1; end
      end else if (exp_vld && y) begin
        exp_vld = 1'b0;
      end
    end
    #1;
    chk("dout_valid", 32'(dout_valid), 32'(exp_vld));
    chk("dout_ovr", 32'(dout_ovr), 32'(exp_ovr));
    if (exp_vld) chk("dout", 32'(dout), 32'(exp_dout));
    if (dout_valid) begin n_vld++; last_dout = dout; end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b1);
    n_vld = 0;
  endtask

  initial begin
    build_h();
    qcnt = 0; exp_vld = 1'b0; exp_ovr = 1'b0; exp_dout = '0;
    n_vld = 0; last_dout = '0;

    // reset state
    do_reset(3);
    chk("rst_dout", 32'(dout), 32'h0);

    // all-ones: saturated full scale
    for (int i = 0; i < 6 * R; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("ones_count", 32'(n_vld), 32'(6 - N));
    chk("ones_value", 32'(last_dout), 32'hFFFF);

    // alternating 1,0: half scale
    do_reset(2);
    for (int i = 0; i < 6 * R; i++) step(1'b0, 1'(~i & 1), 1'b1, 1'b1);
    chk("alt_count", 32'(n_vld), 32'(6 - N));
    chk("alt_value", 32'(last_dout), 32'h8000);

    // all-zeros with din_en at 50%: half the output rate
    do_reset(2);
    last_dout = '1;
    for (int i = 0; i < 12 * R; i++) step(1'b0, 1'b0, 1'(i & 1), 1'b1);
    chk("zero_count", 32'(n_vld), 32'(6 - N));
    chk("zero_value", 32'(last_dout), 32'h0);

    // random bits, random qualification and back-pressure
    do_reset(2);
    for (int i = 0; i < 14 * R; i++)
      step(1'b0, 1'($urandom), 1'($urandom_range(3) != 0), 1'($urandom_range(7) != 0));

    // stalled consumer across two events, then reset 100 bits into a period
    do_reset(2);
    for (int i = 0; i < (N + 2) * R + 100; i++) step(1'b0, 1'($urandom), 1'b1, 1'b0);
    chk("ovr_set", 32'(dout_ovr), 32'h1);
    chk("ovr_hold_vld", 32'(dout_valid), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_vld", 32'(dout_valid), 32'h0);
    chk("midrst_ovr", 32'(dout_ovr), 32'h0);
    n_vld = 0;
    for (int i = 0; i < (N + 1) * R - 1; i++) step(1'b0, 1'($urandom), 1'b1, 1'b1);
    chk("midrst_fill", 32'(n_vld), 32'h0);
    for (int i = 0; i < 2 * R; i++) step(1'b0, 1'($urandom), 1'b1, 1'b1);
    chk("midrst_out", 32'(n_vld), 32'h2);

    // consumer accepts only on the decimation edge
    do_reset(2);
    for (int i = 0; i < (N + 5) * R; i++)
      step(1'b0, 1'($urandom), 1'b1, 1'(qcnt % R == R - 1));
    chk("same_edge_ovr", 32'(dout_ovr), 32'h0);
    chk("same_edge_vld", 32'(dout_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
